uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receive engine for the 16550-style APB UART.
- Samples the serial RXD line using the shared 16x baud `enable` tick and deserialises frames of 5-8 data bits, optional parity and stop bit, formatted per LCR.
- Pushes each received character, with its error flags, into a 16-entry RX FIFO that the register block reads.
- It is the receive-side counterpart of uart_tx and uses the same LCR encoding.

Parameters:
- FIFO_DEPTH, 16, number of RX FIFO entries; must be a power of 2.
- SYNC_STAGES, 2, number of RXD metastability synchroniser flops; minimum 2.

Ports:
- PCLK  in  1  system clock. One clock; reset is asynchronous and active-high.
- PRESET  in  1  asynchronous active-high reset.
- RXD  in  1  serial input; asynchronous to PCLK; idles high.
- enable  in  1  16x baud tick, one PCLK cycle wide.
- LCR  in  8  line control: [1:0] word length - 5; [3] parity enable; [5:3] parity mode; [2] ignored by receiver.
- rx_fifo_pop  in  1  pops the FIFO head; ignored when empty.
- rx_fifo_out  out  11  head entry {BI, FE, PE, data[7:0]}; show-ahead.
- rx_fifo_empty  out  1  FIFO empty.
- rx_fifo_full  out  1  FIFO full.
- rx_fifo_count  out  5  occupancy, 0..16.
- overrun  out  1  sticky; a frame was completed while the FIFO was full.
- overrun_clr  in  1  clears overrun; set takes priority if both occur in the same cycle.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values:
  - All synchroniser flops = 1.
  - State = IDLE; bit_counter = 0; shift register = 0.
  - FIFO emptied: rx_fifo_empty = 1, full = 0, count = 0, rx_fifo_out = 0.
  - overrun = 0; busy = 0.
- Reset mid-frame aborts the frame; nothing is pushed.
- Synchronisation:
  - rxd_s is RXD delayed by SYNC_STAGES flops.
  - All decisions use rxd_s only.
- Timing:
  - bit_counter (4 bits) increments only on `enable` and wraps 15 -> 0.
  - Mid-bit sample point: enable && bit_counter == 7.
  - End of bit period: enable && bit_counter == 15.
- FSM states:
  - IDLE:
    - On enable && rxd_s == 0: go to START and clear bit_counter.
    - busy rises on the following cycle.
  - START:
    - At the sample point, if rxd_s == 1: false start; return to IDLE and clear bit_counter.
    - At end of bit period: go to DATA with bit_idx = 0.
  - DATA:
    - At the sample point: shift[bit_idx] <= rxd_s.
    - At end of bit period, if bit_idx == LCR[1:0] + 4:
      - go to PARITY if LCR[3] = 1, otherwise to STOP.
    - Otherwise: bit_idx++.
    - Data bits above the word length are written as 0.
  - PARITY:
    - At the sample point, capture p.
    - Expected parity by LCR[5:3]:
      - 001 (odd): ~^data
      - 011 (even): ^data
      - 101: 1
      - 111: 0
    - PE = (p != expected).
    - At end of bit period: go to STOP.
  - STOP:
    - At the sample point:
      - FE = (rxd_s == 0).
      - BI = FE && data == 0 && (parity bit == 0 or parity disabled).
      - Push {BI, FE, PE, data}.
    - Next state: WAIT_HIGH if FE = 1, else IDLE.
    - Early exit at mid-stop gives half a bit of resync margin.
  - WAIT_HIGH:
    - Stay until rxd_s == 1, then go to IDLE.
    - Prevents a break from generating repeated frames.
- Push latency: the entry is visible on rx_fifo_out and count one PCLK after the stop-bit sample point.
- FIFO rules:
  - Push when full: entry discarded, contents unchanged, overrun <= 1.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overrun.
  - Push and pop in the same cycle when empty: the push succeeds and the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- LCR is sampled live. Software must not change LCR mid-frame; if it does, behaviour is defined only as "frame may be corrupt, FSM returns to IDLE".

Decomposition:
- Package uart_pkg holds:
  - rx_fsm_t {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH}
  - packed struct rx_entry_t {BI, FE, PE, data[7:0]}
  - LCR field index constants
  - parity mode constants: PAR_ODD = 3'b001, PAR_EVEN = 3'b011, PAR_STICK1 = 3'b101, PAR_STICK0 = 3'b111
- One sub-module: uart_rx_fifo.
  - Parameterised width/depth FIFO with show-ahead output and count.
  - Async active-high reset.
  - Implements the simultaneous push/pop rules above.

Test Plan:
- 8N1, value: LCR = 0x03, enable every cycle, send 0xA5 -> count = 1; rx_fifo_out = 0x0A5 (PE = FE = BI = 0); busy low after the frame.
- Even parity error: LCR = 0x1B, send data 0x01 with parity bit 0 -> entry 0x101 (PE = 1). Repeat with parity bit 1 -> entry 0x001.
- Glitch and short word:
  - RXD low for only 4 enable ticks -> no push, FSM back in IDLE.
  - Then LCR = 0x00, send 0x1F -> entry 0x01F.
- Break: LCR = 0x03, hold RXD low for 200 ticks -> exactly one entry 0x600 (BI = FE = 1, data 0). No further pushes until RXD returns high and a new start bit arrives.
- Overrun: send 17 frames 0x00..0x10 without popping -> count = 16, full = 1, overrun = 1, entries 0x00..0x0F intact.
  - overrun_clr -> overrun = 0.
  - Pop at the 17th push -> no overrun, count stays 16.
- Reset mid-frame: assert PRESET during DATA bit 3 -> next cycle state IDLE, count = 0, overrun = 0. A following clean frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types, LCR field positions and parity helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_fsm_t;

  typedef struct packed {
    logic       bi;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  localparam int LCR_WLS_LSB = 0;
  localparam int LCR_WLS_MSB = 1;
  localparam int LCR_PEN     = 3;
  localparam int LCR_PAR_LSB = 3;
  localparam int LCR_PAR_MSB = 5;

  localparam logic [2:0] PAR_ODD    = 3'b001;
  localparam logic [2:0] PAR_EVEN   = 3'b011;
  localparam logic [2:0] PAR_STICK1 = 3'b101;
  localparam logic [2:0] PAR_STICK0 = 3'b111;

  // Parity bit the transmitter should have sent for this data and mode.
  function automatic logic expected_parity(input logic [2:0] mode, input logic [7:0] data);
    case (mode)
      PAR_ODD:    return ~^data;
      PAR_EVEN:   return ^data;
      PAR_STICK1: return 1'b1;
      PAR_STICK0: return 1'b0;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO with occupancy count; a push into a full FIFO is dropped
// and flagged unless a pop frees the slot in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == FULL_CNT);
  assign o_count    = r_count;
  assign w_pop_ok   = i_pop && !o_empty;
  assign w_push_ok  = i_push && (!o_full || i_pop);
  assign o_overflow = i_push && o_full && !i_pop;
  assign o_data     = o_empty ? '0 : r_mem[r_rd_ptr];

  // NOTE: storage has no reset; the output is forced to zero while empty, so
  // stale contents are never visible and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: all state updates use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receive engine: synchronises RXD, oversamples at 16x, deserialises
// LCR-formatted frames and queues each character with its error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic                          RXD,
  input  logic                          enable,
  input  logic [7:0]                    LCR,
  input  logic                          rx_fifo_pop,
  output logic [10:0]                   rx_fifo_out,
  output logic                          rx_fifo_empty,
  output logic                          rx_fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_fifo_count,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic                          busy
);

  logic [SYNC_STAGES-1:0] r_sync;
  rx_fsm_t                r_state;
  rx_fsm_t                w_state_nxt;
  logic [3:0]             r_bit_cnt;
  logic [2:0]             r_bit_idx;
  logic [7:0]             r_shift;
  logic                   r_par_bit;
  logic                   r_overrun;
  logic                   w_rxd_s;
  logic                   w_sample;
  logic                   w_bit_end;
  logic                   w_last_bit;
  logic                   w_start;
  logic                   w_false_start;
  logic                   w_push;
  logic                   w_overflow;
  logic                   w_par_en;
  rx_entry_t              w_entry;
  logic                   w_unused;

  assign w_rxd_s    = r_sync[SYNC_STAGES-1];
  assign w_sample   = enable && (r_bit_cnt == 4'd7);
  assign w_bit_end  = enable && (r_bit_cnt == 4'd15);
  assign w_last_bit = (r_bit_idx == ({1'b0, LCR[LCR_WLS_MSB:LCR_WLS_LSB]} + 3'd4));
  assign w_par_en   = LCR[LCR_PEN];
  assign busy       = (r_state != IDLE);
  assign overrun    = r_overrun;
  assign w_unused   = ^{LCR[7:6], LCR[2]};

  // Break needs a zero parity bit as well as zero data, since a held-low line
  // reads every bit as 0.
  assign w_entry.data = r_shift;
  assign w_entry.fe   = !w_rxd_s;
  assign w_entry.pe   = w_par_en &&
                        (r_par_bit != expected_parity(LCR[LCR_PAR_MSB:LCR_PAR_LSB], r_shift));
  assign w_entry.bi   = !w_rxd_s && (r_shift == 8'h00) && (!r_par_bit || !w_par_en);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_sync <= '1;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], RXD};
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_start       = 1'b0;
    w_false_start = 1'b0;
    w_push        = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && !w_rxd_s) begin
          w_state_nxt = START;
          w_start     = 1'b1;
        end
      end
      START: begin
        if (w_sample && w_rxd_s) begin
          w_state_nxt   = IDLE;
          w_false_start = 1'b1;
        end else if (w_bit_end) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_bit_end && w_last_bit) w_state_nxt = w_par_en ? PARITY : STOP;
      end
      PARITY: begin
        if (w_bit_end) w_state_nxt = STOP;
      end
      STOP: begin
        // Leaving at mid-stop leaves half a bit to catch the next start edge.
        if (w_sample) begin
          w_push      = 1'b1;
          w_state_nxt = w_rxd_s ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (w_rxd_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start || w_false_start) r_bit_cnt <= '0;
      else if (enable)              r_bit_cnt <= r_bit_cnt + 1'b1;
      // Clearing at frame start leaves bits above the word length at zero.
      if (w_start) begin
        r_shift   <= '0;
        r_bit_idx <= '0;
        r_par_bit <= 1'b0;
      end
      if (r_state == DATA) begin
        if (w_sample)                 r_shift[r_bit_idx] <= w_rxd_s;
        if (w_bit_end && !w_last_bit) r_bit_idx <= r_bit_idx + 1'b1;
      end
      if (r_state == PARITY && w_sample) r_par_bit <= w_rxd_s;
      if (w_overflow)       r_overrun <= 1'b1;
      else if (overrun_clr) r_overrun <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (PCLK),
    .rst        (PRESET),
    .i_push     (w_push),
    .i_data     (w_entry),
    .i_pop      (rx_fifo_pop),
    .o_data     (rx_fifo_out),
    .o_empty    (rx_fifo_empty),
    .o_full     (rx_fifo_full),
    .o_count    (rx_fifo_count),
    .o_overflow (w_overflow)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: frames are serialised onto RXD, the expected
// FIFO entry is queued at drive time and compared when the entry is popped.
module tb_uart_rx;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        RXD = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  LCR = 8'h03;
  logic        rx_fifo_pop = 1'b0;
  logic        overrun_clr = 1'b0;
  logic [10:0] rx_fifo_out;
  logic        rx_fifo_empty;
  logic        rx_fifo_full;
  logic [4:0]  rx_fifo_count;
  logic        overrun;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  int          en_div = 1;
  int          en_cnt = 0;
  int          lat = 0;
  logic [10:0] exp_q[$];

  uart_rx #(.FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .RXD           (RXD),
    .enable        (enable),
    .LCR           (LCR),
    .rx_fifo_pop   (rx_fifo_pop),
    .rx_fifo_out   (rx_fifo_out),
    .rx_fifo_empty (rx_fifo_empty),
    .rx_fifo_full  (rx_fifo_full),
    .rx_fifo_count (rx_fifo_count),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr),
    .busy          (busy)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) begin
    #1;
    en_cnt = (en_cnt + 1 >= en_div) ? 0 : en_cnt + 1;
    enable = (en_cnt == 0);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference entry {BI, FE, PE, data} for a frame sent under the given LCR.
  function automatic logic [10:0] model(input logic [7:0] lcr, input logic [7:0] d,
                                        input logic pbit, input logic stop);
    logic [7:0] dm;
    logic       ep;
    logic       pe;
    logic       fe;
    logic       bi;
    int         nb;
    nb = int'(lcr[1:0]) + 5;
    dm = 8'h00;
    for (int i = 0; i < nb; i++) dm[i] = d[i];
    case (lcr[5:3])
      3'b001:  ep = ~^dm;
      3'b011:  ep = ^dm;
      3'b101:  ep = 1'b1;
      default: ep = 1'b0;
    endcase
    pe = lcr[3] && (pbit != ep);
    fe = !stop;
    bi = fe && (dm == 8'h00) && (!lcr[3] || !pbit);
    return {bi, fe, pe, dm};
  endfunction

  task automatic drive_bit(input logic b);
    RXD = b;
    repeat (16 * en_div) @(posedge PCLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                            input bit expect_push);
    int nb;
    nb = int'(LCR[1:0]) + 5;
    if (expect_push) exp_q.push_back(model(LCR, d, pbit, stop));
    @(posedge PCLK);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (LCR[3]) drive_bit(pbit);
    drive_bit(stop);
    drive_bit(1'b1);
  endtask

  task automatic pop_entry(output logic [10:0] v, output logic emp);
    @(negedge PCLK);
    v = rx_fifo_out;
    emp = rx_fifo_empty;
    rx_fifo_pop = 1'b1;
    @(posedge PCLK);
    #1;
    rx_fifo_pop = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge PCLK);
    total++;
    if ({rx_fifo_empty, rx_fifo_full, rx_fifo_count} !== {1'b1, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL reset_fifo: empty/full/count=%b/%b/%0d want 1/0/0",
               rx_fifo_empty, rx_fifo_full, rx_fifo_count);
    end
    total++;
    if ({rx_fifo_out, overrun, busy} !== {11'h000, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_out: out=%h overrun=%b busy=%b want 000/0/0", rx_fifo_out, overrun, busy);
    end
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    repeat (4) @(posedge PCLK);
  endtask

  task automatic test_8n1();
    logic [10:0] v;
    logic        emp;
    logic [10:0] e;
    LCR = 8'h03;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    @(negedge PCLK);
    total++;
    if (rx_fifo_count !== 5'd1) begin
      bad++;
      $display("FAIL 8n1_count: count=%0d want 1", rx_fifo_count);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL 8n1_busy: busy=%b want 0", busy);
    end
    e = exp_q.pop_front();
    pop_entry(v, emp);
    total++;
    if ({emp, v} !== {1'b0, e}) begin
      bad++;
      $display("FAIL 8n1_entry: empty=%b out=%h want 0/%h", emp, v, e);
    end
  endtask

  task automatic test_parity();
    logic [10:0] v;
    logic        emp;
    logic [10:0] e;
    LCR = 8'h1B; send_frame(8'h01, 1'b0, 1'b1, 1'b1);
    LCR = 8'h1B; send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    LCR = 8'h0B; send_frame(8'h03, 1'b0, 1'b1, 1'b1);
    LCR = 8'h2B; send_frame(8'h00, 1'b0, 1'b1, 1'b1);
    LCR = 8'h3B; send_frame(8'h80, 1'b0, 1'b1, 1'b1);
    @(negedge PCLK);
    total++;
    if (rx_fifo_count !== 5'(exp_q.size())) begin
      bad++;
      $display("FAIL parity_count: count=%0d want %0d", rx_fifo_count, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_entry(v, emp);
      total++;
      if ({emp, v} !== {1'b0, e}) begin
        bad++;
        $display("FAIL parity_entry: empty=%b out=%h want 0/%h", emp, v, e);
      end
    end
  endtask

  task automatic test_glitch();
    logic [10:0] v;
    logic        emp;
    logic [10:0] e;
    LCR = 8'h03;
    @(posedge PCLK);
    #1;
    RXD = 1'b0;
    repeat (4) @(posedge PCLK);
    #1;
    RXD = 1'b1;
    repeat (20) @(negedge PCLK);
    total++;
    if ({busy, rx_fifo_count} !== {1'b0, 5'd0}) begin
      bad++;
      $display("FAIL glitch_idle: busy=%b count=%0d want 0/0", busy, rx_fifo_count);
    end
    LCR = 8'h00;
    send_frame(8'h1F, 1'b0, 1'b1, 1'b1);
    e = exp_q.pop_front();
    pop_entry(v, emp);
    total++;
    if ({emp, v} !== {1'b0, e}) begin
      bad++;
      $display("FAIL short_word: empty=%b out=%h want 0/%h", emp, v, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] v;
    logic        emp;
    logic [10:0] e;
    en_div = 3;
    LCR = 8'h07; send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
    LCR = 8'h01; send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
    LCR = 8'h02; send_frame(8'h55, 1'b0, 1'b1, 1'b1);
    @(negedge PCLK);
    total++;
    if (rx_fifo_count !== 5'd3) begin
      bad++;
      $display("FAIL b2b_count: count=%0d want 3", rx_fifo_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_entry(v, emp);
      total++;
      if ({emp, v} !== {1'b0, e}) begin
        bad++;
        $display("FAIL b2b_entry: empty=%b out=%h want 0/%h", emp, v, e);
      end
    end
    en_div = 1;
    repeat (4) @(posedge PCLK);
  endtask

  task automatic test_break();
    logic [10:0] v;
    logic        emp;
    logic [10:0] e;
    LCR = 8'h03;
    exp_q.push_back(model(LCR, 8'h00, 1'b0, 1'b0));
    @(posedge PCLK);
    #1;
    RXD = 1'b0;
    repeat (200) @(posedge PCLK);
    @(negedge PCLK);
    total++;
    if ({rx_fifo_count, busy} !== {5'd1, 1'b1}) begin
      bad++;
      $display("FAIL break_hold: count=%0d busy=%b want 1/1", rx_fifo_count, busy);
    end
    RXD = 1'b1;
    repeat (40) @(negedge PCLK);
    total++;
    if ({rx_fifo_count, busy} !== {5'd1, 1'b0}) begin
      bad++;
      $display("FAIL break_release: count=%0d busy=%b want 1/0", rx_fifo_count, busy);
    end
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_entry(v, emp);
      total++;
      if ({emp, v} !== {1'b0, e}) begin
        bad++;
        $display("FAIL break_entry: empty=%b out=%h want 0/%h", emp, v, e);
      end
    end
  endtask

  task automatic test_overrun();
    logic [10:0] v;
    logic        emp;
    logic [10:0] e;
    logic [10:0] head;
    logic [4:0]  c0;
    LCR = 8'h03;
    lat = 0;
    c0 = rx_fifo_count;
    fork
      send_frame(8'h00, 1'b0, 1'b1, 1'b1);
      begin
        @(posedge PCLK);
        #1;
        for (int k = 1; k <= 400 && lat == 0; k++) begin
          @(posedge PCLK);
          #2;
          if (rx_fifo_count != c0) lat = k;
        end
      end
    join
    total++;
    if (lat == 0) begin
      bad++;
      $display("FAIL push_timeout: count stayed %0d for 400 cycles", rx_fifo_count);
    end
    for (int i = 1; i <= 16; i++) send_frame(8'(i), 1'b0, 1'b1, i < 16);
    @(negedge PCLK);
    total++;
    if ({rx_fifo_count, rx_fifo_full, overrun} !== {5'd16, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL overrun_set: count=%0d full=%b overrun=%b want 16/1/1",
               rx_fifo_count, rx_fifo_full, overrun);
    end
    @(posedge PCLK);
    #1;
    overrun_clr = 1'b1;
    @(posedge PCLK);
    #1;
    overrun_clr = 1'b0;
    @(negedge PCLK);
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clr: overrun=%b want 0", overrun);
    end
    head = 11'h7FF;
    fork
      send_frame(8'h11, 1'b0, 1'b1, 1'b1);
      begin
        @(posedge PCLK);
        #1;
        repeat (lat - 1) @(posedge PCLK);
        #1;
        head = rx_fifo_out;
        rx_fifo_pop = 1'b1;
        @(posedge PCLK);
        #1;
        rx_fifo_pop = 1'b0;
      end
    join
    e = exp_q.pop_front();
    total++;
    if (head !== e) begin
      bad++;
      $display("FAIL full_pop_head: out=%h want %h", head, e);
    end
    @(negedge PCLK);
    total++;
    if ({rx_fifo_count, rx_fifo_full, overrun} !== {5'd16, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL full_push_pop: count=%0d full=%b overrun=%b want 16/1/0",
               rx_fifo_count, rx_fifo_full, overrun);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_entry(v, emp);
      total++;
      if ({emp, v} !== {1'b0, e}) begin
        bad++;
        $display("FAIL overrun_entry: empty=%b out=%h want 0/%h", emp, v, e);
      end
    end
    fork
      send_frame(8'h22, 1'b0, 1'b1, 1'b1);
      begin
        @(posedge PCLK);
        #1;
        repeat (lat - 1) @(posedge PCLK);
        #1;
        rx_fifo_pop = 1'b1;
        @(posedge PCLK);
        #1;
        rx_fifo_pop = 1'b0;
      end
    join
    @(negedge PCLK);
    total++;
    if (rx_fifo_count !== 5'd1) begin
      bad++;
      $display("FAIL empty_push_pop: count=%0d want 1", rx_fifo_count);
    end
    e = exp_q.pop_front();
    pop_entry(v, emp);
    total++;
    if ({emp, v} !== {1'b0, e}) begin
      bad++;
      $display("FAIL empty_push_pop_entry: empty=%b out=%h want 0/%h", emp, v, e);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] v;
    logic        emp;
    logic [10:0] e;
    LCR = 8'h03;
    send_frame(8'h77, 1'b0, 1'b1, 1'b0);
    @(posedge PCLK);
    #1;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    RXD = 1'b0;
    repeat (8) @(posedge PCLK);
    #1;
    PRESET = 1'b1;
    @(negedge PCLK);
    total++;
    if ({busy, rx_fifo_count, rx_fifo_empty, overrun, rx_fifo_out} !==
        {1'b0, 5'd0, 1'b1, 1'b0, 11'h000}) begin
      bad++;
      $display("FAIL mid_reset: busy=%b count=%0d empty=%b overrun=%b out=%h want 0/0/1/0/000",
               busy, rx_fifo_count, rx_fifo_empty, overrun, rx_fifo_out);
    end
    RXD = 1'b1;
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    repeat (8) @(posedge PCLK);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    @(negedge PCLK);
    total++;
    if (rx_fifo_count !== 5'd1) begin
      bad++;
      $display("FAIL post_reset_count: count=%0d want 1", rx_fifo_count);
    end
    e = exp_q.pop_front();
    pop_entry(v, emp);
    total++;
    if ({emp, v} !== {1'b0, e}) begin
      bad++;
      $display("FAIL post_reset_entry: empty=%b out=%h want 0/%h", emp, v, e);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_back_to_back();
    test_break();
    test_overrun();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
